// File: rtl/id_fwd_stage.sv
// id_fwd_stage -- decode-stage front end.
// Holds the IF/ID pipeline register, keeps a held copy of the synchronous-SRAM
// instruction word across ID stalls, forwards rs/rt operands from NUM_FWD
// prioritised bypass sources (index 0 wins), raises a load-use stall request
// and resolves beq/bne/j.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   stall                stall bus (bit1 = IF/ID, bit2 = ID/EX)
//   flush                kill the instruction in ID
//   if_valid, if_pc      PC presented by IF
//   inst_sram_rdata      instruction word, valid the cycle after capture
//   rf_rdata1/2          regfile rs/rt read data
//   fwd_we/waddr/wdata   bypass sources, packed, source i in slice i
//   fwd_is_load          source i holds a load whose data is not ready yet
//   rs_addr, rt_addr     register read addresses for the regfile
//   stallreq             load-use hazard request
//   id_valid, id_pc      ID holds a live instruction / its PC
//   id_inst              effective instruction (0 when ID is empty)
//   rs_data, rt_data     forwarded operands
//   br_e, br_addr        branch/jump taken and target (target 0 when not taken)

module id_fwd_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_FWD = 3,
    parameter int STALL_W = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STALL_W-1:0]        stall,
    input  logic                      flush,
    input  logic                      if_valid,
    input  logic [DATA_W-1:0]         if_pc,
    input  logic [31:0]               inst_sram_rdata,
    input  logic [DATA_W-1:0]         rf_rdata1,
    input  logic [DATA_W-1:0]         rf_rdata2,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
    input  logic [NUM_FWD-1:0]        fwd_is_load,
    output logic [ADDR_W-1:0]         rs_addr,
    output logic [ADDR_W-1:0]         rt_addr,
    output logic                      stallreq,
    output logic                      id_valid,
    output logic [DATA_W-1:0]         id_pc,
    output logic [31:0]               id_inst,
    output logic [DATA_W-1:0]         rs_data,
    output logic [DATA_W-1:0]         rt_data,
    output logic                      br_e,
    output logic [DATA_W-1:0]         br_addr
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    logic              valid_r;
    logic [DATA_W-1:0] pc_r;
    logic              hold_v;
    logic [31:0]       hold_inst;

    // Only the IF/ID and ID/EX bits of the stall bus matter here.
    logic unused_stall;
    assign unused_stall = ^{stall[STALL_W-1:3], stall[0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r   <= 1'b0;
            pc_r      <= '0;
            hold_v    <= 1'b0;
            hold_inst <= '0;
        end else if (flush) begin
            valid_r <= 1'b0;
            pc_r    <= '0;
            hold_v  <= 1'b0;
        end else if (stall[1] && !stall[2]) begin
            // IF/ID stalled but ID/EX moving: ID drains into a bubble.
            valid_r <= 1'b0;
            pc_r    <= '0;
            hold_v  <= 1'b0;
        end else if (!stall[1]) begin
            valid_r <= if_valid;
            pc_r    <= if_pc;
            hold_v  <= 1'b0;
        end else if (valid_r && !hold_v) begin
            // First stalled edge: the SRAM word is only good this cycle, keep it.
            hold_inst <= inst_sram_rdata;
            hold_v    <= 1'b1;
        end
    end

    assign id_valid = valid_r;
    assign id_pc    = pc_r;
    assign id_inst  = !valid_r ? 32'd0 : (hold_v ? hold_inst : inst_sram_rdata);
    assign rs_addr  = id_inst[25:21];
    assign rt_addr  = id_inst[20:16];

    // Forwarding: scan from lowest priority upward so the lowest matching
    // index is the one left standing.
    logic rs_hit_load;
    logic rt_hit_load;

    always_comb begin
        rs_data     = rf_rdata1;
        rt_data     = rf_rdata2;
        rs_hit_load = 1'b0;
        rt_hit_load = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && fwd_waddr[i*ADDR_W +: ADDR_W] == rs_addr) begin
                rs_data     = fwd_wdata[i*DATA_W +: DATA_W];
                rs_hit_load = fwd_is_load[i];
            end
            if (fwd_we[i] && fwd_waddr[i*ADDR_W +: ADDR_W] == rt_addr) begin
                rt_data     = fwd_wdata[i*DATA_W +: DATA_W];
                rt_hit_load = fwd_is_load[i];
            end
        end
        if (rs_addr == '0) begin
            rs_data     = '0;
            rs_hit_load = 1'b0;
        end
        if (rt_addr == '0) begin
            rt_data     = '0;
            rt_hit_load = 1'b0;
        end
    end

    logic [5:0] opcode;
    logic       uses_rs;
    logic       uses_rt;

    assign opcode  = id_inst[31:26];
    assign uses_rs = (opcode != OP_J);
    assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_BNE);

    assign stallreq = id_valid && ((uses_rs && rs_hit_load) || (uses_rt && rt_hit_load));

    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] br_off;
    logic              br_taken;
    logic [DATA_W-1:0] br_target;

    assign pc_plus4 = pc_r + DATA_W'(4);
    assign br_off   = {{(DATA_W-18){id_inst[15]}}, id_inst[15:0], 2'b00};

    always_comb begin
        br_taken  = 1'b0;
        br_target = pc_plus4 + br_off;
        case (opcode)
            OP_BEQ: br_taken = (rs_data == rt_data);
            OP_BNE: br_taken = (rs_data != rt_data);
            OP_J: begin
                br_taken  = 1'b1;
                br_target = {pc_plus4[DATA_W-1:28], id_inst[25:0], 2'b00};
            end
            default: br_taken = 1'b0;
        endcase
    end

    assign br_e    = id_valid && !stallreq && br_taken;
    assign br_addr = br_e ? br_target : '0;

endmodule

// File: tb/tb_id_fwd_stage.sv
module tb_id_fwd_stage;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int NUM_FWD = 3;
    localparam int STALL_W = 6;

    localparam int F_VALID   = 0;
    localparam int F_PC      = 1;
    localparam int F_INST    = 2;
    localparam int F_RS      = 3;
    localparam int F_RT      = 4;
    localparam int F_STALLRQ = 5;
    localparam int F_BRE     = 6;
    localparam int F_BRADDR  = 7;
    localparam int F_HOLDV   = 8;

    logic                      clk;
    logic                      rst;
    logic [STALL_W-1:0]        stall;
    logic                      flush;
    logic                      if_valid;
    logic [DATA_W-1:0]         if_pc;
    logic [31:0]               inst_sram_rdata;
    logic [DATA_W-1:0]         rf_rdata1;
    logic [DATA_W-1:0]         rf_rdata2;
    logic [NUM_FWD-1:0]        fwd_we;
    logic [NUM_FWD*ADDR_W-1:0] fwd_waddr;
    logic [NUM_FWD*DATA_W-1:0] fwd_wdata;
    logic [NUM_FWD-1:0]        fwd_is_load;
    logic [ADDR_W-1:0]         rs_addr;
    logic [ADDR_W-1:0]         rt_addr;
    logic                      stallreq;
    logic                      id_valid;
    logic [DATA_W-1:0]         id_pc;
    logic [31:0]               id_inst;
    logic [DATA_W-1:0]         rs_data;
    logic [DATA_W-1:0]         rt_data;
    logic                      br_e;
    logic [DATA_W-1:0]         br_addr;

    id_fwd_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_FWD(NUM_FWD),
        .STALL_W(STALL_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .inst_sram_rdata(inst_sram_rdata),
        .rf_rdata1      (rf_rdata1),
        .rf_rdata2      (rf_rdata2),
        .fwd_we         (fwd_we),
        .fwd_waddr      (fwd_waddr),
        .fwd_wdata      (fwd_wdata),
        .fwd_is_load    (fwd_is_load),
        .rs_addr        (rs_addr),
        .rt_addr        (rt_addr),
        .stallreq       (stallreq),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .rs_data        (rs_data),
        .rt_data        (rt_data),
        .br_e           (br_e),
        .br_addr        (br_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    event chk_ev;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            F_VALID:   return {31'd0, id_valid};
            F_PC:      return id_pc;
            F_INST:    return id_inst;
            F_RS:      return rs_data;
            F_RT:      return rt_data;
            F_STALLRQ: return {31'd0, stallreq};
            F_BRE:     return {31'd0, br_e};
            F_BRADDR:  return br_addr;
            F_HOLDV:   return {31'd0, dut.hold_v};
            default:   return 32'hDEADBEEF;
        endcase
    endfunction

    task automatic expect_v(input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Monitor: drains the scoreboard on every falling edge or on demand.
    initial begin
        exp_t e;
        logic [31:0] a;
        forever begin
            @(negedge clk or chk_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = actual(e.sel);
                total++;
                if (a !== e.val) begin
                    bad++;
                    $display("FAIL %s: got 0x%08h want 0x%08h", e.name, a, e.val);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data, input logic ld);
        fwd_we[i]                       = we;
        fwd_waddr[i*ADDR_W +: ADDR_W]   = addr;
        fwd_wdata[i*DATA_W +: DATA_W]   = data;
        fwd_is_load[i]                  = ld;
    endtask

    task automatic clr_src();
        fwd_we      = '0;
        fwd_waddr   = '0;
        fwd_wdata   = '0;
        fwd_is_load = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b0;
        stall           = '0;
        flush           = 1'b0;
        if_valid        = 1'b0;
        if_pc           = '0;
        inst_sram_rdata = '0;
        rf_rdata1       = '0;
        rf_rdata2       = '0;
        clr_src();

        #2;
        expect_v("rst_valid", F_VALID, 32'd0);
        expect_v("rst_pc",    F_PC,    32'd0);
        expect_v("rst_inst",  F_INST,  32'd0);
        expect_v("rst_bre",   F_BRE,   32'd0);
        ->chk_ev;
        #10 rst = 1'b1;
        cyc();

        // Stall hold
        if_valid = 1'b1;
        if_pc    = 32'h1000;
        cyc();
        inst_sram_rdata = 32'h34220005;
        stall           = 6'b000110;
        if_pc           = 32'h2000;
        expect_v("cap_valid", F_VALID, 32'd1);
        expect_v("cap_pc",    F_PC,    32'h1000);
        expect_v("cap_inst",  F_INST,  32'h34220005);
        expect_v("cap_holdv", F_HOLDV, 32'd0);
        cyc();
        inst_sram_rdata = 32'hFFFFFFFF;
        for (int k = 0; k < 3; k++) begin
            expect_v("hold_inst",  F_INST,  32'h34220005);
            expect_v("hold_pc",    F_PC,    32'h1000);
            expect_v("hold_holdv", F_HOLDV, 32'd1);
            cyc();
        end
        expect_v("hold_inst_end", F_INST, 32'h34220005);
        ->chk_ev;

        // Asynchronous reset mid-stall
        #1 rst = 1'b0;
        #1;
        expect_v("arst_valid", F_VALID, 32'd0);
        expect_v("arst_bre",   F_BRE,   32'd0);
        expect_v("arst_holdv", F_HOLDV, 32'd0);
        expect_v("arst_inst",  F_INST,  32'd0);
        ->chk_ev;
        #1 rst = 1'b1;

        // Forward priority on rs (ori r0, r2, 0)
        stall           = '0;
        if_valid        = 1'b1;
        if_pc           = 32'h100;
        inst_sram_rdata = 32'h34400000;
        rf_rdata1       = 32'h55;
        cyc();
        set_src(0, 1'b1, 5'd2, 32'hA, 1'b0);
        set_src(2, 1'b1, 5'd2, 32'hC, 1'b0);
        expect_v("fwd_src0_wins", F_RS, 32'hA);
        expect_v("fwd_no_stall",  F_STALLRQ, 32'd0);
        cyc();
        set_src(0, 1'b0, 5'd2, 32'hA, 1'b0);
        expect_v("fwd_src2_only", F_RS, 32'hC);
        cyc();
        set_src(2, 1'b1, 5'd2, 32'hC, 1'b1);
        expect_v("fwd_load_rs_stall", F_STALLRQ, 32'd1);
        cyc();
        clr_src();
        expect_v("fwd_regfile", F_RS, 32'h55);
        cyc();
        inst_sram_rdata = 32'h34000000;
        set_src(0, 1'b1, 5'd0, 32'hA, 1'b1);
        expect_v("fwd_r0_zero",     F_RS,      32'd0);
        expect_v("fwd_r0_no_stall", F_STALLRQ, 32'd0);
        cyc();

        // ori r2, r1: rt is a destination, a load on r2 must not stall
        clr_src();
        inst_sram_rdata = 32'h34220005;
        set_src(0, 1'b1, 5'd2, 32'h9, 1'b1);
        expect_v("ori_rt_no_stall", F_STALLRQ, 32'd0);
        cyc();

        // add r5, r6, r2: rt forwarding with masking
        clr_src();
        inst_sram_rdata = 32'h00C22820;
        set_src(1, 1'b1, 5'd2, 32'hB, 1'b0);
        set_src(2, 1'b1, 5'd2, 32'hD, 1'b1);
        expect_v("rt_fwd_src1",   F_RT,      32'hB);
        expect_v("rt_mask_load",  F_STALLRQ, 32'd0);
        cyc();
        set_src(1, 1'b0, 5'd2, 32'hB, 1'b0);
        expect_v("rt_load_stall", F_STALLRQ, 32'd1);
        cyc();

        // Load-use on beq r3, r4, -1
        clr_src();
        if_pc = 32'h1000;
        cyc();
        inst_sram_rdata = 32'h1064FFFF;
        rf_rdata1       = 32'd1;
        rf_rdata2       = 32'd7;
        stall           = 6'b000110;
        set_src(0, 1'b1, 5'd3, 32'h99, 1'b1);
        expect_v("lu_stallreq", F_STALLRQ, 32'd1);
        expect_v("lu_bre",      F_BRE,     32'd0);
        expect_v("lu_braddr",   F_BRADDR,  32'd0);
        cyc();
        clr_src();
        set_src(1, 1'b1, 5'd3, 32'd7, 1'b0);
        expect_v("lu_clear_stallreq", F_STALLRQ, 32'd0);
        expect_v("lu_rs_fwd",         F_RS,      32'd7);
        expect_v("lu_beq_taken",      F_BRE,     32'd1);
        expect_v("lu_beq_target",     F_BRADDR,  32'h1000);
        cyc();
        set_src(0, 1'b1, 5'd3, 32'd7, 1'b0);
        set_src(1, 1'b1, 5'd3, 32'd5, 1'b1);
        expect_v("lu_mask_stallreq", F_STALLRQ, 32'd0);
        expect_v("lu_mask_bre",      F_BRE,     32'd1);
        stall = '0;
        cyc();

        // bne r3, r4, -1
        clr_src();
        inst_sram_rdata = 32'h1464FFFF;
        rf_rdata1       = 32'd7;
        rf_rdata2       = 32'd7;
        expect_v("bne_eq_bre",    F_BRE,    32'd0);
        expect_v("bne_eq_braddr", F_BRADDR, 32'd0);
        cyc();
        rf_rdata2 = 32'd8;
        expect_v("bne_ne_bre",    F_BRE,    32'd1);
        expect_v("bne_ne_braddr", F_BRADDR, 32'h1000);
        if_pc = 32'hBFC00000;
        cyc();

        // j 0x100
        inst_sram_rdata = 32'h08000100;
        expect_v("j_pc",     F_PC,     32'hBFC00000);
        expect_v("j_bre",    F_BRE,    32'd1);
        expect_v("j_braddr", F_BRADDR, 32'hB0000400);
        cyc();

        // Flush beats a capture
        flush = 1'b1;
        if_pc = 32'h3000;
        cyc();
        flush = 1'b0;
        expect_v("flush_valid", F_VALID, 32'd0);
        expect_v("flush_pc",    F_PC,    32'd0);
        expect_v("flush_inst",  F_INST,  32'd0);
        expect_v("flush_bre",   F_BRE,   32'd0);
        cyc();
        expect_v("recap_valid", F_VALID, 32'd1);
        expect_v("recap_pc",    F_PC,    32'h3000);
        stall = 6'b000010;
        cyc();
        stall = '0;
        expect_v("bubble_valid", F_VALID, 32'd0);
        expect_v("bubble_pc",    F_PC,    32'd0);
        cyc();
        cyc();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
